// File: rtl/mem_access_stage.sv
// mem_access_stage
//   Memory stage between address generation and writeback. Takes the effective
//   address of a load or store and runs one access on the data-memory bus.
//   The request side is valid/ready and the response side is valid-only. While
//   an access is outstanding the stage stalls upstream. Load data is aligned
//   and extended before it goes to writeback.
//
// Ports
//   clk, clkEn, rst          clock, global clock enable, synchronous reset (high)
//   flushEn                  pipeline flush
//   inValid/inLoad/inStore   upstream op; held by upstream while stallReq=1
//   inSize/inSigned          access size (0 byte, 1 half, 2/3 word), sign-extend
//   inAddr/inStoreData/inRd  effective address, store data, load destination
//   stallReq                 combinational stall to upstream
//   memReq*                  bus request (valid/ready), registered
//   memRespValid/Data        bus response (read data or write ack)
//   outValid/outRd/outData   load result to writeback (1-cycle pulse)
//   storeDone                store acknowledged (1-cycle pulse)
//   misalignFault            misaligned access rejected (1-cycle pulse)
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no access outstanding, ready to accept
// REQ   | request on the bus, waiting for memReqReady
// RESP  | request accepted, waiting for memRespValid
// DRAIN | flushed after the bus took the request; discard the response

module mem_access_stage #(
    parameter int width = 32
) (
    input  logic               clk,
    input  logic               clkEn,
    input  logic               rst,
    input  logic               flushEn,
    input  logic               inValid,
    input  logic               inLoad,
    input  logic               inStore,
    input  logic [1:0]         inSize,
    input  logic               inSigned,
    input  logic [width-1:0]   inAddr,
    input  logic [width-1:0]   inStoreData,
    input  logic [4:0]         inRd,
    output logic               stallReq,
    output logic               memReqValid,
    input  logic               memReqReady,
    output logic               memReqWrite,
    output logic [width-1:0]   memReqAddr,
    output logic [width-1:0]   memReqWdata,
    output logic [width/8-1:0] memReqByteEn,
    input  logic               memRespValid,
    input  logic [width-1:0]   memRespData,
    output logic               outValid,
    output logic [4:0]         outRd,
    output logic [width-1:0]   outData,
    output logic               storeDone,
    output logic               misalignFault
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DRAIN} state_t;

    state_t state;

    logic       lat_load;
    logic       lat_signed;
    logic [1:0] lat_size;
    logic [1:0] lat_off;
    logic [4:0] lat_rd;

    logic             mem_op;
    logic             aligned;
    logic             accept;
    logic [3:0]       be_next;
    logic [width-1:0] wdata_next;
    logic [width-1:0] shifted;
    logic [width-1:0] load_ext;

    assign mem_op = inValid & (inLoad | inStore);
    assign accept = (state == IDLE) & mem_op & aligned & !flushEn;

    always_comb begin
        aligned = 1'b1;
        case (inSize)
            2'd1:    aligned = !inAddr[0];
            2'd2,
            2'd3:    aligned = (inAddr[1:0] == 2'b00);
            default: aligned = 1'b1;
        endcase
    end

    always_comb begin
        be_next    = 4'b1111;
        wdata_next = inStoreData;
        case (inSize)
            2'd0: begin
                be_next    = 4'b0001 << inAddr[1:0];
                wdata_next = {4{inStoreData[7:0]}};
            end
            2'd1: begin
                be_next    = 4'b0011 << inAddr[1:0];
                wdata_next = {2{inStoreData[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = inStoreData;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0, then extend from the access size.
    always_comb begin
        shifted  = memRespData >> {lat_off, 3'b000};
        load_ext = shifted;
        case (lat_size)
            2'd0: load_ext = lat_signed ? {{(width-8){shifted[7]}}, shifted[7:0]}
                                        : {{(width-8){1'b0}}, shifted[7:0]};
            2'd1: load_ext = lat_signed ? {{(width-16){shifted[15]}}, shifted[15:0]}
                                        : {{(width-16){1'b0}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    // Stall drops in the cycle the response arrives so upstream can advance
    // while the FSM returns to IDLE.
    always_comb begin
        stallReq = 1'b0;
        case (state)
            IDLE:        stallReq = accept;
            REQ:         stallReq = 1'b1;
            RESP, DRAIN: stallReq = !memRespValid;
            default:     stallReq = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lat_load      <= 1'b0;
            lat_signed    <= 1'b0;
            lat_size      <= 2'd0;
            lat_off       <= 2'd0;
            lat_rd        <= 5'd0;
            memReqValid   <= 1'b0;
            memReqWrite   <= 1'b0;
            memReqAddr    <= '0;
            memReqWdata   <= '0;
            memReqByteEn  <= '0;
            outValid      <= 1'b0;
            outRd         <= 5'd0;
            outData       <= '0;
            storeDone     <= 1'b0;
            misalignFault <= 1'b0;
        end else if (clkEn) begin
            outValid      <= 1'b0;
            storeDone     <= 1'b0;
            misalignFault <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        // inLoad wins when both load and store are set
                        lat_load     <= inLoad;
                        lat_signed   <= inSigned;
                        lat_size     <= inSize;
                        lat_off      <= inAddr[1:0];
                        lat_rd       <= inRd;
                        memReqValid  <= 1'b1;
                        memReqWrite  <= !inLoad;
                        memReqAddr   <= {inAddr[width-1:2], 2'b00};
                        memReqWdata  <= inLoad ? '0 : wdata_next;
                        memReqByteEn <= be_next;
                        state        <= REQ;
                    end else if (mem_op && !aligned && !flushEn) begin
                        misalignFault <= 1'b1;
                    end
                end
                REQ: begin
                    if (memReqReady) begin
                        // bus owns the access now; a flush must still eat the response
                        memReqValid <= 1'b0;
                        state       <= flushEn ? DRAIN : RESP;
                    end else if (flushEn) begin
                        memReqValid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                RESP: begin
                    if (memRespValid) begin
                        state <= IDLE;
                        if (!flushEn) begin
                            if (lat_load) begin
                                outValid <= 1'b1;
                                outRd    <= lat_rd;
                                outData  <= load_ext;
                            end else begin
                                storeDone <= 1'b1;
                            end
                        end
                    end else if (flushEn) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (memRespValid) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        clkEn, rst, flushEn;
    logic        inValid, inLoad, inStore, inSigned;
    logic [1:0]  inSize;
    logic [31:0] inAddr, inStoreData;
    logic [4:0]  inRd;
    logic        stallReq;
    logic        memReqValid, memReqReady, memReqWrite;
    logic [31:0] memReqAddr, memReqWdata;
    logic [3:0]  memReqByteEn;
    logic        memRespValid;
    logic [31:0] memRespData;
    logic        outValid;
    logic [4:0]  outRd;
    logic [31:0] outData;
    logic        storeDone, misalignFault;

    mem_access_stage #(.width(32)) dut (
        .clk(clk), .clkEn(clkEn), .rst(rst), .flushEn(flushEn),
        .inValid(inValid), .inLoad(inLoad), .inStore(inStore), .inSize(inSize),
        .inSigned(inSigned), .inAddr(inAddr), .inStoreData(inStoreData), .inRd(inRd),
        .stallReq(stallReq), .memReqValid(memReqValid), .memReqReady(memReqReady),
        .memReqWrite(memReqWrite), .memReqAddr(memReqAddr), .memReqWdata(memReqWdata),
        .memReqByteEn(memReqByteEn), .memRespValid(memRespValid), .memRespData(memRespData),
        .outValid(outValid), .outRd(outRd), .outData(outData),
        .storeDone(storeDone), .misalignFault(misalignFault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ld_t;

    req_t        req_q[$];
    ld_t         ld_q[$];
    logic [31:0] st_q[$];
    logic [31:0] mis_q[$];

    int total = 0;
    int bad   = 0;

    // per-cycle expectations set by stimulus, checked by the monitor
    logic ck_stall = 0, ex_stall = 0;
    logic ck_mrv = 0, ex_mrv = 0;
    logic ck_ov = 0, ex_ov = 0;
    logic ck_sd = 0, ex_sd = 0;
    logic ck_mf = 0, ex_mf = 0;
    logic ck_zero = 0;
    logic ck_fields = 0;
    req_t ex_req;
    logic done = 0;
    logic prev_en = 0;

    always @(posedge clk) prev_en <= clkEn && !rst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    req_t mr;
    ld_t  ml;

    always @(negedge clk) begin
        if (ck_stall) chk("stallReq", 32'(stallReq), 32'(ex_stall));
        if (ck_mrv)   chk("memReqValid", 32'(memReqValid), 32'(ex_mrv));
        if (ck_ov)    chk("outValid", 32'(outValid), 32'(ex_ov));
        if (ck_sd)    chk("storeDone", 32'(storeDone), 32'(ex_sd));
        if (ck_mf)    chk("misalignFault", 32'(misalignFault), 32'(ex_mf));
        if (ck_zero) begin
            chk("zero_req", {28'd0, memReqValid, memReqWrite, storeDone, misalignFault}, 32'd0);
            chk("zero_addr", memReqAddr, 32'd0);
            chk("zero_wdata", memReqWdata, 32'd0);
            chk("zero_be", 32'(memReqByteEn), 32'd0);
            chk("zero_out", {26'd0, outValid, outRd}, 32'd0);
            chk("zero_data", outData, 32'd0);
        end
        if (ck_fields) begin
            chk("held_valid", 32'(memReqValid), 32'd1);
            chk("held_addr", memReqAddr, ex_req.addr);
            chk("held_write", 32'(memReqWrite), 32'(ex_req.wr));
            chk("held_be", 32'(memReqByteEn), 32'(ex_req.be));
            if (ex_req.wr) chk("held_wdata", memReqWdata, ex_req.wdata);
        end
        if (!rst && clkEn && memReqValid && memReqReady) begin
            if (req_q.size() == 0) begin
                total++; bad++;
                $display("FAIL req_unexpected actual=%h required=none", memReqAddr);
            end else begin
                mr = req_q.pop_front();
                chk("req_addr", memReqAddr, mr.addr);
                chk("req_write", 32'(memReqWrite), 32'(mr.wr));
                chk("req_be", 32'(memReqByteEn), 32'(mr.be));
                if (mr.wr) chk("req_wdata", memReqWdata, mr.wdata);
            end
        end
        if (prev_en && outValid) begin
            if (ld_q.size() == 0) begin
                total++; bad++;
                $display("FAIL load_unexpected actual=%h required=none", outData);
            end else begin
                ml = ld_q.pop_front();
                chk("load_rd", 32'(outRd), 32'(ml.rd));
                chk("load_data", outData, ml.data);
            end
        end
        if (prev_en && storeDone) begin
            total++;
            if (st_q.size() == 0) begin
                bad++;
                $display("FAIL store_unexpected actual=1 required=0");
            end else void'(st_q.pop_front());
        end
        if (prev_en && misalignFault) begin
            total++;
            if (mis_q.size() == 0) begin
                bad++;
                $display("FAIL misalign_unexpected actual=1 required=0");
            end else void'(mis_q.pop_front());
        end
        if (done) begin
            chk("left_req", 32'(req_q.size()), 32'd0);
            chk("left_load", 32'(ld_q.size()), 32'd0);
            chk("left_store", 32'(st_q.size()), 32'd0);
            chk("left_misalign", 32'(mis_q.size()), 32'd0);
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
        ck_stall = 0; ck_mrv = 0; ck_ov = 0; ck_sd = 0; ck_mf = 0;
        ck_zero = 0; ck_fields = 0;
    endtask

    task automatic expect_stall(input logic v);
        ck_stall = 1; ex_stall = v;
    endtask

    task automatic op(input logic ld, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd);
        inValid = 1; inLoad = ld; inStore = !ld; inSize = sz; inSigned = sg;
        inAddr = a; inStoreData = sd; inRd = rd;
    endtask

    // Fast access: ready at once, response one cycle after the handshake.
    task automatic do_access(input logic ld, input logic [1:0] sz, input logic sg,
                             input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                             input logic [31:0] resp, input logic [31:0] exp_d,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd);
        op(ld, sz, sg, a, sd, rd);
        memReqReady = 1;
        req_q.push_back('{addr: a & 32'hFFFF_FFFC, wr: !ld, wdata: exp_wd, be: exp_be});
        if (ld) ld_q.push_back('{rd: rd, data: exp_d});
        else    st_q.push_back(a);
        expect_stall(1);
        tick;                                   // T+1: request on bus
        inValid = 0;
        ck_mrv = 1; ex_mrv = 1;
        expect_stall(1);
        tick;                                   // T+2: response
        memReqReady = 0;
        memRespValid = 1; memRespData = resp;
        ck_mrv = 1; ex_mrv = 0;
        expect_stall(0);
        tick;                                   // T+3: result
        memRespValid = 0;
        if (ld) begin ck_ov = 1; ex_ov = 1; end
        else    begin ck_sd = 1; ex_sd = 1; end
        tick;
        ck_ov = 1; ex_ov = 0; ck_sd = 1; ex_sd = 0;
        expect_stall(0);
        tick;
    endtask

    initial begin
        clkEn = 1; rst = 1; flushEn = 0;
        inValid = 0; inLoad = 0; inStore = 0; inSize = 0; inSigned = 0;
        inAddr = 0; inStoreData = 0; inRd = 0;
        memReqReady = 0; memRespValid = 0; memRespData = 0;
        ex_req = '0;
        tick; tick;
        ck_zero = 1; expect_stall(0);
        tick;
        rst = 0;
        tick;

        // loads/stores with immediate bus
        do_access(1, 2'd0, 1, 32'h0000_1003, 32'h0, 5'd7,  32'h80FF_FF7F, 32'hFFFF_FF80, 4'b1000, 32'h0);
        do_access(1, 2'd1, 0, 32'h0000_7002, 32'h0, 5'd1,  32'h8001_1234, 32'h0000_8001, 4'b1100, 32'h0);
        do_access(1, 2'd1, 1, 32'h0000_7000, 32'h0, 5'd2,  32'h0000_F00D, 32'hFFFF_F00D, 4'b0011, 32'h0);
        do_access(1, 2'd0, 0, 32'h0000_7001, 32'h0, 5'd4,  32'h0000_AB00, 32'h0000_00AB, 4'b0010, 32'h0);
        do_access(1, 2'd2, 1, 32'h0000_7004, 32'h0, 5'd5,  32'h8765_4321, 32'h8765_4321, 4'b1111, 32'h0);
        do_access(0, 2'd0, 0, 32'h0000_7003, 32'h0000_00EE, 5'd0, 32'h0, 32'h0, 4'b1000, 32'hEEEE_EEEE);
        do_access(0, 2'd3, 0, 32'h0000_7008, 32'hCAFE_F00D, 5'd0, 32'h0, 32'h0, 4'b1111, 32'hCAFE_F00D);

        // half store, ready delayed
        op(0, 2'd1, 0, 32'h0000_2002, 32'h1234_ABCD, 5'd0);
        memReqReady = 0;
        ex_req = '{addr: 32'h0000_2000, wr: 1'b1, wdata: 32'hABCD_ABCD, be: 4'b1100};
        req_q.push_back(ex_req);
        st_q.push_back(32'h0000_2002);
        expect_stall(1);
        tick;
        inValid = 0;
        for (int i = 0; i < 3; i++) begin
            ck_fields = 1; expect_stall(1);
            memReqReady = (i == 2);
            tick;
        end
        memReqReady = 0;
        ck_mrv = 1; ex_mrv = 0; expect_stall(1);
        tick;
        memRespValid = 1; memRespData = 32'h0;
        expect_stall(0);
        tick;
        memRespValid = 0;
        ck_sd = 1; ex_sd = 1;
        tick;
        ck_sd = 1; ex_sd = 0;
        tick;

        // misaligned word and half
        for (int i = 0; i < 2; i++) begin
            if (i == 0) op(1, 2'd2, 0, 32'h0000_3001, 32'h0, 5'd6);
            else        op(1, 2'd1, 0, 32'h0000_3003, 32'h0, 5'd6);
            mis_q.push_back(inAddr);
            expect_stall(0);
            ck_mrv = 1; ex_mrv = 0;
            tick;
            inValid = 0;
            ck_mf = 1; ex_mf = 1; ck_mrv = 1; ex_mrv = 0; ck_ov = 1; ex_ov = 0;
            tick;
            ck_mf = 1; ex_mf = 0;
            tick;
        end

        // flush while waiting for the response
        op(1, 2'd2, 0, 32'h0000_4000, 32'h0, 5'd3);
        memReqReady = 1;
        req_q.push_back('{addr: 32'h0000_4000, wr: 1'b0, wdata: 32'h0, be: 4'b1111});
        tick;
        inValid = 0;
        tick;                                   // RESP
        memReqReady = 0;
        flushEn = 1; expect_stall(1);
        tick;                                   // DRAIN
        flushEn = 0; expect_stall(1);
        tick;
        memRespValid = 1; memRespData = 32'h5555_5555;
        expect_stall(0);
        tick;
        memRespValid = 0;
        ck_ov = 1; ex_ov = 0; expect_stall(0);
        tick;
        ck_ov = 1; ex_ov = 0; expect_stall(0);
        tick;

        // reset while in RESP, then a stray response
        op(1, 2'd1, 1, 32'h0000_5004, 32'h0, 5'd9);
        memReqReady = 1;
        req_q.push_back('{addr: 32'h0000_5004, wr: 1'b0, wdata: 32'h0, be: 4'b0011});
        tick;
        inValid = 0;
        tick;                                   // RESP
        memReqReady = 0;
        rst = 1;
        tick;
        rst = 0;
        ck_zero = 1; expect_stall(0);
        memRespValid = 1; memRespData = 32'h1111_2222;
        tick;
        memRespValid = 0;
        ck_ov = 1; ex_ov = 0; expect_stall(0);
        tick;
        ck_ov = 1; ex_ov = 0;
        tick;

        // clock enable low for 4 cycles while in REQ
        op(1, 2'd2, 0, 32'h0000_6008, 32'h0, 5'd12);
        memReqReady = 0;
        ex_req = '{addr: 32'h0000_6008, wr: 1'b0, wdata: 32'h0, be: 4'b1111};
        req_q.push_back(ex_req);
        ld_q.push_back('{rd: 5'd12, data: 32'hDEAD_BEEF});
        expect_stall(1);
        tick;                                   // REQ
        inValid = 0;
        clkEn = 0;
        memReqReady = 1;
        for (int i = 0; i < 4; i++) begin
            ck_fields = 1; expect_stall(1);
            ck_ov = 1; ex_ov = 0;
            tick;
        end
        clkEn = 1;
        ck_fields = 1;
        tick;                                   // RESP
        memReqReady = 0;
        memRespValid = 1; memRespData = 32'hDEAD_BEEF;
        expect_stall(0);
        tick;
        memRespValid = 0;
        ck_ov = 1; ex_ov = 1;
        tick;
        ck_ov = 1; ex_ov = 0;
        tick;
        tick;
        done = 1;
    end

endmodule
